// File: rtl/alu_seq.sv
// Sequential execute unit: single-cycle logic/arithmetic ops, iterative one-bit-per-cycle
// shifts, with valid/ready handshakes on both the request and result sides.
module alu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b1101;
  localparam logic [3:0] OP_SRA = 4'b1111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        ctrl_reg, ctrl_next;
  logic [XLEN-1:0]   acc_reg, acc_next;
  logic [XLEN-1:0]   result_reg, result_next;
  logic [SHW-1:0]    count_reg, count_next;

  logic [XLEN-1:0]   alu_value;
  logic [XLEN-1:0]   shift_value;
  logic [SHW-1:0]    amount;
  logic              is_shift;
  logic              accept;

  assign amount   = b[SHW-1:0];
  assign is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
  assign accept   = in_valid && (state_reg == IDLE);

  always_comb begin
    alu_value = '0;
    case (alu_ctrl)
      OP_AND:  alu_value = a & b;
      OP_OR:   alu_value = a | b;
      OP_ADD:  alu_value = a + b;
      OP_XOR:  alu_value = a ^ b;
      OP_SUB:  alu_value = a - b;
      default: alu_value = '0;
    endcase
  end

  // One bit position per cycle on the latched operation.
  always_comb begin
    shift_value = acc_reg;
    case (ctrl_reg)
      OP_SLL:  shift_value = {acc_reg[XLEN-2:0], 1'b0};
      OP_SRL:  shift_value = {1'b0, acc_reg[XLEN-1:1]};
      OP_SRA:  shift_value = {acc_reg[XLEN-1], acc_reg[XLEN-1:1]};
      default: shift_value = acc_reg;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    ctrl_next   = ctrl_reg;
    acc_next    = acc_reg;
    result_next = result_reg;
    count_next  = count_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          ctrl_next = alu_ctrl;
          if (!is_shift) begin
            result_next = alu_value;
            state_next  = DONE;
          end else if (amount == '0) begin
            result_next = a;
            state_next  = DONE;
          end else begin
            acc_next   = a;
            count_next = amount;
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_next   = shift_value;
        count_next = count_reg - 1'b1;
        if (count_reg == SHW'(1)) begin
          result_next = shift_value;
          state_next  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      ctrl_reg   <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      ctrl_reg   <= ctrl_next;
      acc_reg    <= acc_next;
      result_reg <= result_next;
      count_reg  <= count_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;
  assign zero      = (result_reg == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq: result, zero flag and handshake latency per op,
// plus hand-written backpressure and mid-shift reset sequences.
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int checks = 0;
  int errors = 0;

  alu_seq #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its result; out_ready is left as set by the caller.
  task automatic issue(input logic [3:0] c, input logic [31:0] va, input logic [31:0] vb,
                       output int lat);
    @(negedge clk);
    chk("in_ready_before_issue", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; alu_ctrl = c; a = va; b = vb;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat <= 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    out_ready = 1'b1;
    issue(v.ctrl, v.a, v.b, lat);
    chk({v.name, "_out_valid"}, {31'b0, out_valid}, 32'd1);
    chk({v.name, "_result"}, result, v.res);
    chk({v.name, "_zero"}, {31'b0, zero}, {31'b0, v.z});
    chk({v.name, "_latency"}, lat, v.lat);
    $display("op %s ctrl=%b a=%h b=%h result=%h zero=%b latency=%0d",
             v.name, v.ctrl, v.a, v.b, result, zero, lat);
    @(negedge clk);
    chk({v.name, "_in_ready_after"}, {31'b0, in_ready}, 32'd1);
    chk({v.name, "_out_valid_after"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{"add",     4'b0010, 32'd5,         32'd7,         32'd12,        1'b0, 1};
    vecs[1]  = '{"sub_zero",4'b0110, 32'h0000_0007, 32'h0000_0007, 32'h0,         1'b1, 1};
    vecs[2]  = '{"sub_wrap",4'b0110, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1};
    vecs[3]  = '{"sra4",    4'b1111, 32'h8000_0000, 32'h24,        32'hF800_0000, 1'b0, 5};
    vecs[4]  = '{"srl4",    4'b1101, 32'h8000_0000, 32'h24,        32'h0800_0000, 1'b0, 5};
    vecs[5]  = '{"sll0",    4'b0101, 32'h1234_5678, 32'h20,        32'h1234_5678, 1'b0, 1};
    vecs[6]  = '{"illegal", 4'b0100, 32'h0000_FFFF, 32'h0000_1234, 32'h0,         1'b1, 1};
    vecs[7]  = '{"or",      4'b0001, 32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0, 1'b0, 1};
    vecs[8]  = '{"xor",     4'b0011, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 1'b0, 1};
    vecs[9]  = '{"sll31",   4'b0101, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 32};
    vecs[10] = '{"sra1_pos",4'b1111, 32'h7000_0000, 32'h0000_0001, 32'h3800_0000, 1'b0, 2};
    vecs[11] = '{"srl31",   4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32};

    reset = 1'b1; in_valid = 1'b0; alu_ctrl = '0; a = '0; b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_result", result, 32'h0);
    chk("reset_zero", {31'b0, zero}, 32'd1);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Backpressure: result held while out_ready is low; a concurrent request is ignored.
    out_ready = 1'b0;
    issue(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, lat);
    chk("bp_latency", lat, 1);
    in_valid = 1'b1; alu_ctrl = 4'b0011; a = 32'h1; b = 32'h2;
    for (int k = 0; k < 3; k++) begin
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_result", result, 32'hF000_F000);
      chk("bp_zero", {31'b0, zero}, 32'd0);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_result_final", result, 32'hF000_F000);
    $display("op backpressure_and result=%h held 3 cycles", result);
    @(negedge clk);
    chk("bp_in_ready_after", {31'b0, in_ready}, 32'd1);
    chk("bp_out_valid_after", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("bp_no_extra_accept", {31'b0, out_valid}, 32'd0);

    // Reset mid-shift: SLL by 31, reset asserted 10 cycles after the accept edge.
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = 4'b0101; a = 32'h0000_0001; b = 32'h0000_001F;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mid_result", result, 32'h0);
    chk("rst_mid_zero", {31'b0, zero}, 32'd1);
    begin
      int seen = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("rst_mid_no_result", seen, 0);
    end
    $display("op reset_mid_shift aborted, result=%h", result);
    run_vec('{"xor_after_rst", 4'b0011, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 1'b0, 1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
